// File: rtl/seq101_arb_ctrl.sv
// Two-requester round-robin front end that serialises a captured word MSB first
// into an overlapping "101" Moore detector and reports per-word and running match totals.
module seq101_arb_ctrl #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0_valid,
  input  logic [NBITS-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [NBITS-1:0] req1_data,
  output logic             req1_ready,
  output logic             busy,
  output logic             serial_bit,
  output logic             det_match,
  output logic             done,
  output logic [3:0]       result_count,
  output logic             result_id,
  output logic [7:0]       total_matches
);

  localparam int IW = $clog2(NBITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] S0   = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S10  = 2'd2;
  localparam logic [1:0] S101 = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       det_q, det_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [3:0]       word_cnt_q, word_cnt_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       result_count_q, result_count_d;
  logic             result_id_q, result_id_d;
  logic [7:0]       total_q, total_d;

  logic       grant0, grant1;
  logic [1:0] det_nxt;
  logic [3:0] cnt_nxt;

  function automatic logic [1:0] next_det(input logic [1:0] s, input logic b);
    case (s)
      S0:      next_det = b ? S1   : S0;
      S1:      next_det = b ? S1   : S10;
      S10:     next_det = b ? S101 : S0;
      default: next_det = b ? S1   : S10;
    endcase
  endfunction

  // Tie goes to whichever requester was not served last.
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);
  assign grant0 = req0_valid && !grant1;

  assign req0_ready = rst_n && ena && (state_q == IDLE) && grant0;
  assign req1_ready = rst_n && ena && (state_q == IDLE) && grant1;

  assign serial_bit = rst_n && (state_q == SHIFT) && shreg_q[NBITS-1];
  assign det_nxt    = next_det(det_q, shreg_q[NBITS-1]);
  assign cnt_nxt    = word_cnt_q + {3'b000, (det_nxt == S101)};

  always_comb begin
    state_d        = state_q;
    det_d          = det_q;
    shreg_d        = shreg_q;
    bit_idx_d      = bit_idx_q;
    word_cnt_d     = word_cnt_q;
    id_d           = id_q;
    last_grant_d   = last_grant_q;
    result_count_d = result_count_q;
    result_id_d    = result_id_q;
    total_d        = total_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d      = SHIFT;
          shreg_d      = grant1 ? req1_data : req0_data;
          id_d         = grant1;
          last_grant_d = grant1;
          det_d        = S0;
          bit_idx_d    = '0;
          word_cnt_d   = '0;
        end
      end
      SHIFT: begin
        shreg_d    = shreg_q << 1;
        det_d      = det_nxt;
        word_cnt_d = cnt_nxt;
        bit_idx_d  = bit_idx_q + IW'(1);
        // Results are published on entry to DONE so they are valid alongside the pulse.
        if (bit_idx_q == IW'(NBITS - 1)) begin
          state_d        = DONE;
          result_count_d = cnt_nxt;
          result_id_d    = id_q;
          total_d        = total_q + {4'b0000, cnt_nxt};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      det_q          <= S0;
      bit_idx_q      <= '0;
      word_cnt_q     <= '0;
      id_q           <= 1'b0;
      last_grant_q   <= 1'b1;
      result_count_q <= '0;
      result_id_q    <= 1'b0;
      total_q        <= '0;
    end else if (ena) begin
      state_q        <= state_d;
      det_q          <= det_d;
      bit_idx_q      <= bit_idx_d;
      word_cnt_q     <= word_cnt_d;
      id_q           <= id_d;
      last_grant_q   <= last_grant_d;
      result_count_q <= result_count_d;
      result_id_q    <= result_id_d;
      total_q        <= total_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ena) shreg_q <= shreg_d;
  end

  assign busy          = rst_n && (state_q != IDLE);
  assign det_match     = rst_n && (det_q == S101);
  assign done          = rst_n && ena && (state_q == DONE);
  assign result_count  = result_count_q;
  assign result_id     = result_id_q;
  assign total_matches = total_q;

endmodule

// File: tb/tb_seq101_arb_ctrl.sv
// Directed plus randomised bench for seq101_arb_ctrl with a word-level reference model.
module tb_seq101_arb_ctrl;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n, ena;
  logic          req0_valid, req1_valid;
  logic [NB-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          busy, serial_bit, det_match, done;
  logic [3:0]    result_count;
  logic          result_id;
  logic [7:0]    total_matches;

  int n_chk  = 0;
  int n_fail = 0;

  logic       m_last;
  logic [7:0] m_total;

  seq101_arb_ctrl #(.NBITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .busy(busy), .serial_bit(serial_bit), .det_match(det_match), .done(done),
    .result_count(result_count), .result_id(result_id), .total_matches(total_matches)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // True when the bits at MSB-first positions k, k+1, k+2 of w spell "101".
  function automatic bit tri101(input logic [NB-1:0] w, input int k);
    return (w[NB-1-k] == 1'b1) && (w[NB-2-k] == 1'b0) && (w[NB-3-k] == 1'b1);
  endfunction

  function automatic int count101(input logic [NB-1:0] w);
    int c = 0;
    for (int k = 0; k <= NB - 3; k++) if (tri101(w, k)) c++;
    return c;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ser"}, serial_bit, 0);
    check({tag, "_det"}, det_match, 0);
    check({tag, "_rdy0"}, req0_ready, 0);
    check({tag, "_rdy1"}, req1_ready, 0);
  endtask

  task automatic jitter_inputs();
    req0_valid = 1'($urandom);
    req1_valid = 1'($urandom);
    req0_data  = NB'($urandom);
    req1_data  = NB'($urandom);
  endtask

  // Called just after a negedge with the DUT idle; returns at the negedge of the first idle cycle after DONE.
  task automatic serve(input logic v0, input logic [NB-1:0] d0, input logic v1, input logic [NB-1:0] d1,
                       input int gap_at, input int gap_len);
    logic          w1;
    logic [NB-1:0] word;
    int            cnt;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    #1;
    w1   = v1 && (!v0 || (m_last == 1'b0));
    word = w1 ? d1 : d0;
    cnt  = count101(word);
    check("grant_rdy0", req0_ready, v0 && !w1);
    check("grant_rdy1", req1_ready, w1);
    check("grant_busy", busy, 0);
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      jitter_inputs();
      if (i == gap_at) begin
        ena = 1'b0;
        repeat (gap_len) begin
          #1;
          check("hold_ser", serial_bit, word[NB-1-i]);
          check("hold_busy", busy, 1);
          check("hold_done", done, 0);
          check("hold_rdy", {req0_ready, req1_ready}, 0);
          @(negedge clk);
        end
        ena = 1'b1;
      end
      #1;
      check("shift_ser", serial_bit, word[NB-1-i]);
      check("shift_det", det_match, (i >= 3) && tri101(word, i - 3));
      check("shift_busy", busy, 1);
      check("shift_done", done, 0);
      check("shift_rdy", {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    jitter_inputs();
    #1;
    m_total = m_total + 8'(cnt);
    m_last  = w1;
    check("done_pulse", done, 1);
    check("done_count", result_count, cnt);
    check("done_id", result_id, w1);
    check("done_total", total_matches, m_total);
    check("done_det", det_match, tri101(word, NB - 3));
    check("done_rdy", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_ser", serial_bit, 0);
    check("idle_count", result_count, cnt);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h3C; req1_data = 8'hC3;
    m_last = 1'b1; m_total = 8'd0;

    // Reset held two cycles with both requesters asking.
    repeat (2) begin
      @(posedge clk); @(negedge clk); #1;
      check_quiet("rst");
      check("rst_count", result_count, 0);
      check("rst_id", result_id, 0);
      check("rst_total", total_matches, 0);
    end
    rst_n = 1'b1;
    serve(1'b1, 8'h3C, 1'b1, 8'hC3, 99, 0);

    serve(1'b1, 8'hA8, 1'b0, 8'h00, 99, 0);
    serve(1'b0, 8'h00, 1'b1, 8'h12, 99, 0);
    serve(1'b1, 8'hAA, 1'b1, 8'hFF, 99, 0);
    serve(1'b1, 8'hAA, 1'b1, 8'hFF, 99, 0);
    serve(1'b1, 8'h05, 1'b0, 8'h00, 99, 0);

    // Enable low while idle must suppress ready.
    ena = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) begin
      #1;
      check("ena_idle_rdy", {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    ena = 1'b1;

    serve(1'b1, 8'hAA, 1'b0, 8'h00, 3, 5);
    serve(1'b1, 8'hAA, 1'b0, 8'h00, 0, 2);
    serve(1'b0, 8'h00, 1'b1, 8'hB5, 7, 3);

    for (int n = 0; n < 30; n++) begin
      logic a, b;
      a = 1'($urandom);
      b = 1'($urandom);
      if (!a && !b) a = 1'b1;
      serve(a, NB'($urandom), b, NB'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
    end

    // Reset in the middle of a word aborts it.
    req0_valid = 1'b1; req0_data = 8'hAA; req1_valid = 1'b0;
    #1;
    check("abort_grant", req0_ready, 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check_quiet("abort");
      check("abort_total", total_matches, 0);
      check("abort_count", result_count, 0);
    end
    rst_n = 1'b1; req0_valid = 1'b0;
    m_total = 8'd0; m_last = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 86; n++) serve(1'b1, 8'hAA, 1'b0, 8'h00, 99, 0);
    check("wrap_total", total_matches, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq101_arb_ctrl.md
SEQ101_ARB_CTRL -- requirements
Module: seq101_arb_ctrl

Interface
REQ-001 SHALL provide parameter: NBITS, 8, bits per request word; legal range 4..16.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL provide port: ena  input  1  global enable; low freezes all registers.
REQ-005 SHALL provide port: req0_valid  input  1  requester 0 holds a word.
REQ-006 SHALL provide port: req0_data  input  NBITS  requester 0 word.
REQ-007 SHALL provide port: req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 SHALL provide ports req1_valid / req1_data / req1_ready with the same directions, widths and meanings for requester 1.
REQ-009 SHALL provide port: busy  output  1  high in SHIFT and DONE states.
REQ-010 SHALL provide port: serial_bit  output  1  bit fed to the detector this cycle.
REQ-011 SHALL provide port: det_match  output  1  Moore detector output; high in state S101.
REQ-012 SHALL provide port: done  output  1  one-cycle pulse; result valid.
REQ-013 SHALL provide port: result_count  output  4  "101" matches in the last word, held until next done.
REQ-014 SHALL provide port: result_id  output  1  requester of the last word, held until next done.
REQ-015 SHALL provide port: total_matches  output  8  running match total since reset; wraps 255->0.

Function
REQ-016 SHALL implement controller FSM IDLE, SHIFT, DONE.
REQ-017 In IDLE with at least one valid: SHALL grant one requester, assert its ready combinationally that cycle, capture its data, clear detector to S0, clear word count and bit index, and enter SHIFT.
REQ-018 Handshake: transfer occurs only on valid&ready in the same cycle; ready SHALL be low outside IDLE, and never high for both requesters at once.
REQ-019 Arbitration SHALL be round-robin: single valid wins; on simultaneous valid, the requester not granted last wins; last_grant resets to 1, so req0 wins the first tie.
REQ-020 SHIFT SHALL feed captured bits MSB first, one per enabled cycle, for exactly NBITS cycles, then enter DONE; serial_bit SHALL be 0 outside SHIFT.
REQ-021 Detector SHALL be an overlapping Moore "101" FSM with states S0, S1, S10, S101.
- S0: 1->S1, 0->S0
- S1: 1->S1, 0->S10
- S10: 1->S101, 0->S0
- S101: 1->S1, 0->S10
REQ-022 Word count SHALL increment on each edge at which the detector enters S101. det_match SHALL rise the cycle after the completing bit; a match on the last bit SHALL be counted and shown in DONE.
REQ-023 DONE SHALL last one cycle: pulse done, load result_count and result_id, add the word count to total_matches modulo 256, then return to IDLE.
- Latency: accept at cycle T; done at T+NBITS+1.
- Next grant no earlier than T+NBITS+2.
REQ-024 With ena low, SHALL hold all state and outputs; ready SHALL be low and done SHALL not pulse; operation resumes exactly where it stopped.
REQ-025 Valid changes during SHIFT/DONE SHALL have no effect; detector state SHALL not carry across words.

Reset
REQ-026 With rst_n low at a clock edge, SHALL reset:
- FSM to IDLE, detector to S0
- result_count, result_id, total_matches, word count, bit index to 0
- last_grant to 1
REQ-027 During and after reset, SHALL hold busy, done, serial_bit, det_match and both readys at 0; reset mid-SHIFT SHALL abort the word with no done pulse.

Verification
REQ-028 Reset: rst_n low 2 cycles, then both valids high -> all outputs 0 in reset; first grant is req0 on the first cycle after release.
REQ-029 req0_data=0xA8 alone -> req0_ready at T, serial_bit 1,0,1,0,1,0,0,0 over T+1..T+8, done at T+9, result_count=2, result_id=0, total_matches=2.
REQ-030 Both valid, req0=0xAA, req1=0xFF held -> req0 served first, result_count=3; req1 granted in the first IDLE cycle after, result_count=0, result_id=1.
REQ-031 0x05 (last bits 101) -> det_match high in DONE cycle; result_count=1.
REQ-032 ena low 5 cycles mid-SHIFT -> done delayed exactly 5 cycles; count unchanged versus the uninterrupted run.
REQ-033 rst_n low at T+4 of a 0xAA word -> no done, outputs 0; 86 consecutive 0xAA words -> total_matches = 258 mod 256 = 2.
